// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, FSM state encoding and helpers shared by the
// sequential ALU, its multiplier and its bench.
package alu_pkg;

   // 4-bit operation codes
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_BEQ = 4'd2;
   localparam logic [3:0] ALU_BLT = 4'd3;
   localparam logic [3:0] ALU_AND = 4'd4;
   localparam logic [3:0] ALU_OR  = 4'd5;
   localparam logic [3:0] ALU_XOR = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_SLL = 4'd8;
   localparam logic [3:0] ALU_SRL = 4'd9;
   localparam logic [3:0] ALU_SRA = 4'd10;
   localparam logic [3:0] ALU_MUL = 4'd11;
   localparam logic [3:0] ALU_BNE = 4'd12;
   localparam logic [3:0] ALU_BGE = 4'd13;

   // Control FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // True for the opcodes whose outcome is the change_pc condition
   function automatic logic is_branch(input logic [3:0] opcode);
      return (opcode == ALU_BEQ) || (opcode == ALU_BLT) ||
             (opcode == ALU_BNE) || (opcode == ALU_BGE);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request and result channels of the sequential ALU.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. The source holds valid and its
// payload stable until that edge; valid never depends on ready. ready may
// depend on valid and on the state of the sink.
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   // request channel (decode -> ALU)
   logic             ip_valid;
   logic             ip_ready;
   logic [WIDTH-1:0] ip_0;
   logic [WIDTH-1:0] ip_1;
   logic [3:0]       opcode;
   // result channel (ALU -> writeback / PC update)
   logic             op_valid;
   logic             op_ready;
   logic [WIDTH-1:0] op_0;
   logic             change_pc;
   logic             op_illegal;

   // upstream / downstream environment around the ALU
   modport master (
      output ip_valid, ip_0, ip_1, opcode, op_ready,
      input  ip_ready, op_valid, op_0, change_pc, op_illegal
   );

   // the ALU itself
   modport slave (
      input  ip_valid, ip_0, ip_1, opcode, op_ready,
      output ip_ready, op_valid, op_0, change_pc, op_illegal
   );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one partial product per
// cycle, WIDTH iterations. Returns the low WIDTH bits of the unsigned
// product. done is high during the last iteration cycle and product is the
// value the accumulator takes at the end of that cycle, so the caller can
// register it on the same edge.
module alu_mul_iter #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   logic             busy;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nx;

   // Add the shifted multiplicand whenever the current multiplier bit is set
   always_comb begin
      acc_nx = acc;
      if (mplier[0]) begin
         acc_nx = acc + mcand;
      end
   end

   assign done    = busy && (cnt == SHW'(WIDTH - 1));
   assign product = acc_nx;

   // Operand latch on start, then one shift-add iteration per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
      end else if (busy) begin
         acc    <= acc_nx;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked, parametrised ALU. Single-cycle ops produce a result
// one edge after the request handshake; MUL (only when ALU_MUL_EN is
// defined) runs on the iterative multiplier and takes WIDTH edges. Without
// ALU_MUL_EN, opcode 11 is reported as illegal like 14 and 15.
// WIDTH must be a power of two and at least 4.
module alu_seq
   import alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_seq_if.slave    bus,
   output state_t      dbg_state
);

   state_t           state, state_nx;
   logic             ip_ready_int;
   logic             accept;
   logic             take;
   logic             load;
   logic             req_mul;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   logic [WIDTH-1:0] a, b;
   logic [SHW-1:0]   shamt;
   logic             eq, lt_s, cond;
   logic [WIDTH-1:0] dp_res;
   logic             dp_pc, dp_ill;

   logic [WIDTH-1:0] res_q, res_nx;
   logic             pc_q, pc_nx;
   logic             ill_q, ill_nx;

   assign a     = bus.ip_0;
   assign b     = bus.ip_1;
   assign shamt = b[SHW-1:0];
   assign eq    = (a == b);
   assign lt_s  = ($signed(a) < $signed(b));

   // Single-cycle datapath, evaluated on the live request operands
   always_comb begin
      dp_res = '0;
      cond   = 1'b0;
      dp_ill = 1'b0;
      case (bus.opcode)
         ALU_ADD: dp_res = a + b;
         ALU_SUB: dp_res = a - b;
         ALU_AND: dp_res = a & b;
         ALU_OR:  dp_res = a | b;
         ALU_XOR: dp_res = a ^ b;
         ALU_SLT: dp_res = {{(WIDTH-1){1'b0}}, lt_s};
         ALU_SLL: dp_res = a << shamt;
         ALU_SRL: dp_res = a >> shamt;
         ALU_SRA: dp_res = $signed(a) >>> shamt;
         ALU_BEQ: cond   = eq;
         ALU_BNE: cond   = !eq;
         ALU_BLT: cond   = lt_s;
         ALU_BGE: cond   = !lt_s;
`ifdef ALU_MUL_EN
         ALU_MUL: dp_res = '0;   // product comes from the multiplier
`else
         ALU_MUL: dp_ill = 1'b1;
`endif
         default: dp_ill = 1'b1;
      endcase
   end

   assign dp_pc = is_branch(bus.opcode) && cond;

`ifdef ALU_MUL_EN
   logic mul_start;

   assign req_mul   = (bus.opcode == ALU_MUL);
   assign mul_start = accept && req_mul;

   alu_mul_iter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   assign req_mul     = 1'b0;
   assign mul_done    = 1'b0;
   assign mul_product = '0;
`endif

   // A new request is taken when idle, or when the held result leaves
   assign ip_ready_int = (state == ST_IDLE) ||
                         ((state == ST_DONE) && bus.op_ready);
   assign accept       = bus.ip_valid && ip_ready_int;

   // Next-state and result-register load selection
   always_comb begin
      state_nx = state;
      take     = 1'b0;
      load     = 1'b0;
      res_nx   = dp_res;
      pc_nx    = dp_pc;
      ill_nx   = dp_ill;
      case (state)
         ST_IDLE: begin
            if (accept) take = 1'b1;
         end
         ST_BUSY: begin
            if (mul_done) begin
               state_nx = ST_DONE;
               load     = 1'b1;
               res_nx   = mul_product;
               pc_nx    = 1'b0;
               ill_nx   = 1'b0;
            end
         end
         ST_DONE: begin
            if (bus.op_ready) begin
               if (accept) take = 1'b1;
               else        state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      // A taken request is handled identically from IDLE and from DONE
      if (take) begin
         if (req_mul) begin
            state_nx = ST_BUSY;
         end else begin
            state_nx = ST_DONE;
            load     = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Result registers; held untouched until the next load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
         pc_q  <= 1'b0;
         ill_q <= 1'b0;
      end else if (load) begin
         res_q <= res_nx;
         pc_q  <= pc_nx;
         ill_q <= ill_nx;
      end
   end

   assign bus.ip_ready   = ip_ready_int;
   assign bus.op_valid   = (state == ST_DONE);
   assign bus.op_0       = res_q;
   assign bus.change_pc  = pc_q;
   assign bus.op_illegal = ill_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random stimulus for alu_seq at WIDTH=32 with a
// queue-based scoreboard on the result channel. Builds with or without
// ALU_MUL_EN.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W  = 32;
   localparam int EW = W + 2;   // {op_illegal, change_pc, op_0}

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(W)) bus();
   state_t dbg_state;

   logic rdy_main = 1'b0;
   logic rdy_rnd  = 1'b0;
   logic rand_bp  = 1'b0;
   assign bus.op_ready = rdy_main | (rand_bp & rdy_rnd);

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      rdy_rnd = ($urandom_range(0, 3) != 0);
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [EW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [EW-1:0] pack(input logic ill, input logic pc, input logic [W-1:0] r);
      return {ill, pc, r};
   endfunction

   // Reference behaviour written from the opcode table
   function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0]        r;
      logic                pc, il;
      logic signed [W-1:0] sa, sb;
      r = '0; pc = 1'b0; il = 1'b0; sa = a; sb = b;
      case (op)
         4'd0:  r  = a + b;
         4'd1:  r  = a - b;
         4'd2:  pc = (a == b);
         4'd3:  pc = (sa < sb);
         4'd4:  r  = a & b;
         4'd5:  r  = a | b;
         4'd6:  r  = a ^ b;
         4'd7:  r  = (sa < sb) ? 32'd1 : 32'd0;
         4'd8:  r  = a << b[4:0];
         4'd9:  r  = a >> b[4:0];
         4'd10: r  = sa >>> b[4:0];
`ifdef ALU_MUL_EN
         4'd11: r  = a * b;
`else
         4'd11: il = 1'b1;
`endif
         4'd12: pc = (a != b);
         4'd13: pc = (sa >= sb);
         default: il = 1'b1;
      endcase
      return {il, pc, r};
   endfunction

   // Scoreboard and hold monitor on the result channel
   logic          held = 1'b0;
   logic [EW-1:0] held_v = '0;
   always @(negedge clk) begin
      logic [EW-1:0] cur;
      logic [EW-1:0] e;
      cur = {bus.op_illegal, bus.change_pc, bus.op_0};
      if (held && rst_n) begin
         check("hold_valid", bus.op_valid, 1);
         check("hold_data", cur, held_v);
      end
      if (rst_n && bus.op_valid && bus.op_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("sb_result", cur, e);
         end
      end
      held   = rst_n && bus.op_valid && !bus.op_ready;
      held_v = cur;
   end

   // ---------------- driver ----------------
   // Presents one request, leaves ip_valid high, returns 1 time unit after
   // the handshake edge.
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [EW-1:0] exp);
      int n;
      n = 0;
      bus.opcode   = op;
      bus.ip_0     = a;
      bus.ip_1     = b;
      bus.ip_valid = 1'b1;
      @(negedge clk);
      while (!bus.ip_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.ip_ready) begin
         check("send_timeout", n, 0);
         bus.ip_valid = 1'b0;
      end else begin
         exp_q.push_back(exp);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int cycles);
      bus.ip_valid = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int          n;
      int unsigned t0;
      logic [3:0]  op;
      logic [W-1:0] ra, rb;

      bus.ip_valid = 1'b0;
      bus.ip_0     = '0;
      bus.ip_1     = '0;
      bus.opcode   = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_op_valid", bus.op_valid, 0);
      check("rst_op_0", bus.op_0, 0);
      check("rst_change_pc", bus.change_pc, 0);
      check("rst_op_illegal", bus.op_illegal, 0);
      check("rst_state", dbg_state, ST_IDLE);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ip_ready_after_rst", bus.ip_ready, 1);

      // single-cycle latency and streaming throughput
      rdy_main = 1'b1;
      send(ALU_ADD, 32'd102, 32'd93, pack(0, 0, 32'd195));
      check("add_latency", bus.op_valid, 1);
      check("add_direct", bus.op_0, 195);
      t0 = cyc;
      send(ALU_SUB, 32'd91, 32'd2,  pack(0, 0, 32'd89));
      send(ALU_SUB, 32'd2,  32'd91, pack(0, 0, 32'hFFFF_FFA7));
      send(ALU_BEQ, 32'd2,  32'd2,  pack(0, 1, 32'd0));
      send(ALU_BEQ, 32'd8,  32'd2,  pack(0, 0, 32'd0));
      send(ALU_BLT, 32'd61, 32'd65, pack(0, 1, 32'd0));
      send(ALU_BLT, 32'd524, 32'd65, pack(0, 0, 32'd0));
      send(ALU_BLT, 32'hFFFF_FFFF, 32'd1, pack(0, 1, 32'd0));
      send(ALU_SRA, 32'h8000_0000, 32'h24, pack(0, 0, 32'hF800_0000));
      send(4'd15, 32'd5, 32'd6, pack(1, 0, 32'd0));
      send(4'd14, 32'd5, 32'd6, pack(1, 0, 32'd0));
      send(ALU_BNE, 32'd3, 32'd4, pack(0, 1, 32'd0));
      send(ALU_BGE, 32'hFFFF_FFFF, 32'd1, pack(0, 0, 32'd0));
      send(ALU_BGE, 32'd5, 32'd5, pack(0, 1, 32'd0));
      send(ALU_SLT, 32'hFFFF_FFFE, 32'd1, pack(0, 0, 32'd1));
      send(ALU_SLL, 32'd1, 32'd33, pack(0, 0, 32'd2));
      send(ALU_SRL, 32'h8000_0000, 32'd31, pack(0, 0, 32'd1));
      send(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, pack(0, 0, 32'h00F0_1234));
      send(ALU_OR,  32'hF000_0000, 32'h0000_000F, pack(0, 0, 32'hF000_000F));
      send(ALU_XOR, 32'hFFFF_0000, 32'hFF00_FF00, pack(0, 0, 32'h00FF_FF00));
      check("throughput", cyc - t0, 19);
      idle(2);

      // MUL: long latency, or illegal when the multiplier is not built
`ifdef ALU_MUL_EN
      send(ALU_MUL, 32'd7, 32'd6, pack(0, 0, 32'd42));
      bus.ip_valid = 1'b0;
      check("mul_state_busy", dbg_state, ST_BUSY);
      n = 0;
      while (!bus.op_valid && n < 100) begin
         if (bus.ip_ready) check("mul_ip_ready", bus.ip_ready, 0);
         n++;
         @(posedge clk);
         #1;
      end
      check("mul_latency", n, 32);
      check("mul_result", bus.op_0, 42);
`else
      send(ALU_MUL, 32'd7, 32'd6, pack(1, 0, 32'd0));
      bus.ip_valid = 1'b0;
      check("mul_illegal_latency", bus.op_valid, 1);
      check("mul_illegal_flag", bus.op_illegal, 1);
`endif
      idle(2);

      // backpressure: result held, no new request accepted
      rdy_main = 1'b0;
      send(ALU_ADD, 32'd10, 32'd23, pack(0, 0, 32'd33));
      bus.ip_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", bus.op_valid, 1);
         check("bp_data", bus.op_0, 33);
         check("bp_ip_ready", bus.ip_ready, 0);
         @(posedge clk);
         #1;
      end
      rdy_main = 1'b1;
      send(ALU_ADD, 32'd1, 32'd1, pack(0, 0, 32'd2));
      check("b2b_valid", bus.op_valid, 1);
      check("b2b_data", bus.op_0, 2);
      idle(2);

      // random ops under random backpressure
      rdy_main = 1'b0;
      rand_bp  = 1'b1;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         ra = $urandom();
         rb = $urandom();
         if ($urandom_range(0, 3) == 0) begin
            ra = 32'($urandom_range(0, 9));
            rb = 32'($urandom_range(0, 9));
         end
         send(op, ra, rb, model(op, ra, rb));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      bus.ip_valid = 1'b0;
      rand_bp  = 1'b0;
      rdy_main = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("random_drain", exp_q.size(), 0);
      idle(2);

      // reset during an in-flight operation
`ifdef ALU_MUL_EN
      send(ALU_MUL, 32'd9, 32'd9, pack(0, 0, 32'd81));
      bus.ip_valid = 1'b0;
      repeat (10) @(posedge clk);
`else
      rdy_main = 1'b0;
      send(ALU_BEQ, 32'd5, 32'd5, pack(0, 1, 32'd0));
      bus.ip_valid = 1'b0;
      @(posedge clk);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_back());
      check("mid_rst_op_valid", bus.op_valid, 0);
      check("mid_rst_op_0", bus.op_0, 0);
      check("mid_rst_change_pc", bus.change_pc, 0);
      check("mid_rst_op_illegal", bus.op_illegal, 0);
      check("mid_rst_state", dbg_state, ST_IDLE);
      rdy_main = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.op_valid) check("no_stale_result", bus.op_valid, 0);
      end
      send(ALU_ADD, 32'd1, 32'd2, pack(0, 0, 32'd3));
      check("post_rst_data", bus.op_0, 3);
      idle(3);

      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
